cmd_issuer: RTL and testbench
=============================

Name: cmd_issuer

Overview:
Initiator side of the MD5 command protocol. It serialises one host-level command into the byte stream the FPGA command parser consumes, then collects any response bytes and the parser's completion acknowledge. Supported commands: SET hash, PROC chars, RET match, TEST countdown, STR_LEN, CLOSE. It sits on the host/bench side of the 16-bit link, or drives the parser directly in loopback builds.

Parameters:
TIMEOUT_CYCLES, 65535, idle cycles tolerated in any wait state before abort
STR_LEN_DEFAULT, 16'h98, shadow string length in bits (19 chars) after reset

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
cmd_start  in  1  one-cycle request; sampled only in IDLE
cmd_op  in  3  1=SET 2=PROC 3=RET 4=TEST 5=STR_LEN 6=CLOSE
cmd_hash  in  128  target hash for SET
cmd_num_bytes  in  16  payload length for PROC
cmd_str_len  in  16  string length in bits for STR_LEN
pl_data  in  8  PROC payload byte
pl_valid  in  1  payload byte available
pl_ready  out  1  payload byte consumed
tx_data  out  8  byte to parser
tx_valid  out  1  tx_data valid
tx_ready  in  1  parser link accepts byte (transfer = tx_valid & tx_ready)
rsp_data  in  8  response byte from parser
rsp_valid  in  1  response byte strobe
ack_in  in  1  parser command-done pulse
match_in  in  1  parser match flag, valid with ack_in
busy  out  1  high from accepted cmd_start until done
done  out  1  one-cycle completion pulse
match  out  1  match_in latched at ack_in of a PROC command
byte_pos  out  16  match position from RET, MSB first
rsp_out_data  out  8  RET string or TEST countdown byte
rsp_out_valid  out  1  one-cycle strobe per rsp_out_data byte
error  out  1  pulses with done on a bad op, timeout or premature ack

Behaviour:
- Reset: all outputs 0; str_len shadow = STR_LEN_DEFAULT; state IDLE. Reset mid-command aborts at once with no done pulse.
- IDLE: busy=0. On cmd_start: latch op and all operands, set busy=1 next cycle. Op 0 or 7: no bytes sent, done=1 and error=1 on the following cycle.
- SEND_HI: tx 8'h00 (unused MSB of the 16-bit command word). SEND_OP: tx {5'b0,op}.
- SEND_PARAM by op:
  - SET: 16 hash bytes, [127:120] first.
  - PROC: num_bytes[15:8], then num_bytes[7:0].
  - STR_LEN: cmd_str_len[15:8], then [7:0]; the shadow updates on the last byte's transfer.
  - RET/TEST/CLOSE: no parameters.
- tx rules: tx_data stays stable while tx_valid=1 and tx_ready=0. The next byte is presented the cycle after a transfer; back-to-back transfers are allowed, one byte per cycle.
- SEND_PAYLOAD (PROC only, skipped when num_bytes=0):
  - tx_data=pl_data, tx_valid=pl_valid, pl_ready=tx_ready, all combinational in this state.
  - A 16-bit counter counts transfers; exit when it reaches num_bytes.
  - pl_ready=0 in every other state.
- WAIT_RSP (RET, TEST):
  - RET expects 2 + (str_len>>3) bytes. The first two load byte_pos MSB first; the rest are forwarded on rsp_out_* with one cycle of latency.
  - TEST expects 10 bytes, all forwarded.
  - rsp_valid outside WAIT_RSP is ignored.
  - ack_in arriving before the expected count completes: done=1, error=1, return to IDLE.
- WAIT_ACK: on ack_in, go to FIN; for PROC, match<=match_in. ack_in and the last rsp byte in the same cycle: the byte is consumed first, then the ack is honoured in that same cycle.
- FIN: done=1 for one cycle, busy=0 the next cycle, back to IDLE. byte_pos and match hold until overwritten.
- Timeout: a counter clears on every transfer, rsp byte or ack. When it reaches TIMEOUT_CYCLES in any non-IDLE state: done=1, error=1, IDLE.

Test Plan:
- SET with hash 0x00112233...EEFF, tx_ready=1 -> tx stream 00,01,00,11,...,FF (18 bytes); ack after 3 cycles -> done=1, error=0.
- PROC num_bytes=3, payload 41,42,43, tx_ready toggling 1/0 -> tx 00,02,00,03,41,42,43 with data stable while stalled; ack_in with match_in=1 -> match=1.
- STR_LEN 0x0020, then RET; parser returns 00,05,'a','b','c','d' -> byte_pos=0x0005, four rsp_out_valid strobes carrying a..d, then done on ack.
- TEST -> tx 00,04; rsp 0A..01 forwarded in order; done on ack.
- Faults: op=0 -> no tx bytes, done+error. RET with ack_in after 1 rsp byte -> error. TIMEOUT_CYCLES=16 with no ack -> done+error after 16 idle cycles.
- Reset asserted during SEND_PAYLOAD -> tx_valid=0, busy=0 next cycle, no done; str_len shadow back to 0x98.

Source files
------------

// File: rtl/cmd_issuer.sv
`timescale 1ns/1ps
// cmd_issuer
// Host-side initiator for the MD5 command protocol. Serialises one command
// into the byte stream the parser consumes (0x00, op, parameters, payload),
// then collects response bytes and the parser's completion acknowledge.
module cmd_issuer #(
    parameter int          TIMEOUT_CYCLES  = 65535,
    parameter logic [15:0] STR_LEN_DEFAULT = 16'h0098
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         cmd_start,
    input  logic [2:0]   cmd_op,
    input  logic [127:0] cmd_hash,
    input  logic [15:0]  cmd_num_bytes,
    input  logic [15:0]  cmd_str_len,
    input  logic [7:0]   pl_data,
    input  logic         pl_valid,
    output logic         pl_ready,
    output logic [7:0]   tx_data,
    output logic         tx_valid,
    input  logic         tx_ready,
    input  logic [7:0]   rsp_data,
    input  logic         rsp_valid,
    input  logic         ack_in,
    input  logic         match_in,
    output logic         busy,
    output logic         done,
    output logic         match,
    output logic [15:0]  byte_pos,
    output logic [7:0]   rsp_out_data,
    output logic         rsp_out_valid,
    output logic         error
);
    localparam logic [2:0]  OP_SET     = 3'd1;
    localparam logic [2:0]  OP_PROC    = 3'd2;
    localparam logic [2:0]  OP_RET     = 3'd3;
    localparam logic [2:0]  OP_TEST    = 3'd4;
    localparam logic [2:0]  OP_STR_LEN = 3'd5;
    localparam logic [15:0] TMO_LAST   = 16'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SEND_HI, S_SEND_OP, S_SEND_PARAM,
        S_SEND_PAYLOAD, S_WAIT_RSP, S_WAIT_ACK, S_FIN
    } state_t;

    state_t         state_q, state_d;
    logic [2:0]     op_q, op_d;
    logic [127:0]   param_q, param_d;     // outgoing parameter bytes, MSB first
    logic [15:0]    arg_q, arg_d;         // num_bytes for PROC, new length for STR_LEN
    logic [15:0]    str_len_q, str_len_d; // shadow of the parser's string length
    logic [3:0]     idx_q, idx_d;         // parameter byte index
    logic [15:0]    cnt_q, cnt_d;         // payload transfers or response bytes
    logic [15:0]    tmo_q, tmo_d;
    logic           busy_q, busy_d;
    logic           done_q, done_d;
    logic           error_q, error_d;
    logic           match_q, match_d;
    logic [15:0]    byte_pos_q, byte_pos_d;
    logic [7:0]     rsp_out_data_q, rsp_out_data_d;
    logic           rsp_out_valid_q, rsp_out_valid_d;

    logic           xfer_s;
    logic           abort_s;
    logic           activity_s;
    logic           waiting_s;
    logic           rsp_last_s;
    logic [3:0]     param_last_s;
    logic [15:0]    rsp_total_s;

    // Link-side drive: fixed bytes come from registers, payload passes straight through.
    always_comb begin
        tx_data  = 8'h00;
        tx_valid = 1'b0;
        pl_ready = 1'b0;
        case (state_q)
            S_SEND_HI: begin
                tx_valid = 1'b1;
                tx_data  = 8'h00;
            end
            S_SEND_OP: begin
                tx_valid = 1'b1;
                tx_data  = {5'b00000, op_q};
            end
            S_SEND_PARAM: begin
                tx_valid = 1'b1;
                tx_data  = param_q[127:120];
            end
            S_SEND_PAYLOAD: begin
                tx_valid = pl_valid;
                tx_data  = pl_data;
                pl_ready = tx_ready;
            end
            default: begin
                tx_valid = 1'b0;
                tx_data  = 8'h00;
            end
        endcase
    end

    assign xfer_s       = tx_valid & tx_ready;
    assign param_last_s = (op_q == OP_SET) ? 4'd15 : 4'd1;
    assign rsp_total_s  = (op_q == OP_RET) ? (16'd2 + (str_len_q >> 3)) : 16'd10;
    assign rsp_last_s   = rsp_valid && ((cnt_q + 16'd1) == rsp_total_s);
    assign waiting_s    = (state_q != S_IDLE) && (state_q != S_FIN);
    assign activity_s   = xfer_s | ack_in | (rsp_valid && (state_q == S_WAIT_RSP));

    // Next-state and next-output computation for the whole command sequence.
    always_comb begin
        state_d         = state_q;
        op_d            = op_q;
        param_d         = param_q;
        arg_d           = arg_q;
        str_len_d       = str_len_q;
        idx_d           = idx_q;
        cnt_d           = cnt_q;
        tmo_d           = tmo_q;
        match_d         = match_q;
        byte_pos_d      = byte_pos_q;
        rsp_out_data_d  = rsp_out_data_q;
        rsp_out_valid_d = 1'b0;
        abort_s         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_start) begin
                    op_d  = cmd_op;
                    arg_d = (cmd_op == OP_STR_LEN) ? cmd_str_len : cmd_num_bytes;
                    case (cmd_op)
                        OP_SET:     param_d = cmd_hash;
                        OP_PROC:    param_d = {cmd_num_bytes, 112'd0};
                        OP_STR_LEN: param_d = {cmd_str_len, 112'd0};
                        default:    param_d = 128'd0;
                    endcase
                    idx_d = 4'd0;
                    cnt_d = 16'd0;
                    if ((cmd_op == 3'd0) || (cmd_op == 3'd7)) begin
                        state_d = S_FIN;
                        abort_s = 1'b1;
                    end else begin
                        state_d = S_SEND_HI;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEND_HI: begin
                if (xfer_s) begin
                    state_d = S_SEND_OP;
                end else begin
                    state_d = S_SEND_HI;
                end
            end
            S_SEND_OP: begin
                if (xfer_s) begin
                    case (op_q)
                        OP_SET, OP_PROC, OP_STR_LEN: state_d = S_SEND_PARAM;
                        OP_RET, OP_TEST:             state_d = S_WAIT_RSP;
                        default:                     state_d = S_WAIT_ACK;
                    endcase
                end else begin
                    state_d = S_SEND_OP;
                end
            end
            S_SEND_PARAM: begin
                if (xfer_s) begin
                    param_d = {param_q[119:0], 8'h00};
                    idx_d   = idx_q + 4'd1;
                    if (idx_q == param_last_s) begin
                        idx_d = 4'd0;
                        if (op_q == OP_STR_LEN) begin
                            str_len_d = arg_q;
                        end else begin
                            str_len_d = str_len_q;
                        end
                        if ((op_q == OP_PROC) && (arg_q != 16'd0)) begin
                            state_d = S_SEND_PAYLOAD;
                        end else begin
                            state_d = S_WAIT_ACK;
                        end
                    end else begin
                        state_d = S_SEND_PARAM;
                    end
                end else begin
                    state_d = S_SEND_PARAM;
                end
            end
            S_SEND_PAYLOAD: begin
                if (xfer_s) begin
                    cnt_d = cnt_q + 16'd1;
                    if ((cnt_q + 16'd1) == arg_q) begin
                        state_d = S_WAIT_ACK;
                    end else begin
                        state_d = S_SEND_PAYLOAD;
                    end
                end else begin
                    state_d = S_SEND_PAYLOAD;
                end
            end
            S_WAIT_RSP: begin
                if (rsp_valid) begin
                    cnt_d = cnt_q + 16'd1;
                    if ((op_q == OP_RET) && (cnt_q < 16'd2)) begin
                        byte_pos_d = {byte_pos_q[7:0], rsp_data};
                    end else begin
                        rsp_out_valid_d = 1'b1;
                        rsp_out_data_d  = rsp_data;
                    end
                end else begin
                    cnt_d = cnt_q;
                end
                // A byte arriving with the ack is consumed before the ack is judged.
                if (ack_in) begin
                    state_d = S_FIN;
                    abort_s = !rsp_last_s;
                end else if (rsp_last_s) begin
                    state_d = S_WAIT_ACK;
                end else begin
                    state_d = S_WAIT_RSP;
                end
            end
            S_WAIT_ACK: begin
                if (ack_in) begin
                    state_d = S_FIN;
                    if (op_q == OP_PROC) begin
                        match_d = match_in;
                    end else begin
                        match_d = match_q;
                    end
                end else begin
                    state_d = S_WAIT_ACK;
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Watchdog: a busy state with no link activity for too long aborts the command.
        if (waiting_s) begin
            if (activity_s) begin
                tmo_d = 16'd0;
            end else if (tmo_q == TMO_LAST) begin
                tmo_d   = 16'd0;
                state_d = S_FIN;
                abort_s = 1'b1;
            end else begin
                tmo_d = tmo_q + 16'd1;
            end
        end else begin
            tmo_d = 16'd0;
        end

        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_FIN);
        error_d = abort_s;
    end

    // State and registered outputs; synchronous reset aborts any command silently.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            op_q            <= 3'd0;
            param_q         <= 128'd0;
            arg_q           <= 16'd0;
            str_len_q       <= STR_LEN_DEFAULT;
            idx_q           <= 4'd0;
            cnt_q           <= 16'd0;
            tmo_q           <= 16'd0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            error_q         <= 1'b0;
            match_q         <= 1'b0;
            byte_pos_q      <= 16'd0;
            rsp_out_data_q  <= 8'h00;
            rsp_out_valid_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            op_q            <= op_d;
            param_q         <= param_d;
            arg_q           <= arg_d;
            str_len_q       <= str_len_d;
            idx_q           <= idx_d;
            cnt_q           <= cnt_d;
            tmo_q           <= tmo_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            error_q         <= error_d;
            match_q         <= match_d;
            byte_pos_q      <= byte_pos_d;
            rsp_out_data_q  <= rsp_out_data_d;
            rsp_out_valid_q <= rsp_out_valid_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
    assign match         = match_q;
    assign byte_pos      = byte_pos_q;
    assign rsp_out_data  = rsp_out_data_q;
    assign rsp_out_valid = rsp_out_valid_q;

endmodule

// File: tb/tb_cmd_issuer.sv
`timescale 1ns/1ps
// tb_cmd_issuer
// Directed bench: a command-level model builds the expected tx byte stream,
// forwarded response bytes, byte_pos and error outcome; one monitor compares
// the DUT against it every cycle.
module tb_cmd_issuer;
    localparam int TMO = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         cmd_start;
    logic [2:0]   cmd_op;
    logic [127:0] cmd_hash;
    logic [15:0]  cmd_num_bytes;
    logic [15:0]  cmd_str_len;
    logic [7:0]   pl_data = 8'h00;
    logic         pl_valid = 1'b0;
    logic         pl_ready;
    logic [7:0]   tx_data;
    logic         tx_valid;
    logic         tx_ready = 1'b1;
    logic [7:0]   rsp_data;
    logic         rsp_valid;
    logic         ack_in;
    logic         match_in;
    logic         busy;
    logic         done;
    logic         match;
    logic [15:0]  byte_pos;
    logic [7:0]   rsp_out_data;
    logic         rsp_out_valid;
    logic         error;

    cmd_issuer #(.TIMEOUT_CYCLES(TMO), .STR_LEN_DEFAULT(16'h0098)) dut (
        .clk(clk), .reset(reset), .cmd_start(cmd_start), .cmd_op(cmd_op),
        .cmd_hash(cmd_hash), .cmd_num_bytes(cmd_num_bytes), .cmd_str_len(cmd_str_len),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .ack_in(ack_in), .match_in(match_in),
        .busy(busy), .done(done), .match(match), .byte_pos(byte_pos),
        .rsp_out_data(rsp_out_data), .rsp_out_valid(rsp_out_valid), .error(error)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  exp_rsp[$];
    logic [7:0]  pay_q[$];
    logic [7:0]  rsp_src[$];
    logic        exp_err;
    logic [15:0] mdl_str_len;
    logic [15:0] mdl_byte_pos;
    int          done_count = 0;
    int          done_base = 0;
    int          cyc = 0;
    int          last_xfer_cyc = 0;
    int          done_cyc = 0;
    int          last_n = 0;
    logic        toggle_en = 1'b0;
    logic        ready_level = 1'b1;
    logic        pl_take = 1'b0;
    logic        rsp_fwd;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data = 8'h00;
    logic        prev_done = 1'b0;
    logic        prev_fwd = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: sample away from the active edge and compare against the model.
    always @(negedge clk) begin
        cyc++;
        pl_take = pl_valid & pl_ready;
        if (reset) begin
            prev_stall = 1'b0;
            prev_done  = 1'b0;
            prev_fwd   = 1'b0;
        end else begin
            if (prev_stall && tx_valid) check("tx_stable", {24'd0, tx_data}, {24'd0, prev_data});
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL tx_unexpected: got %0h expected no byte", tx_data);
                end else begin
                    check("tx_byte", {24'd0, tx_data}, {24'd0, exp_tx.pop_front()});
                end
                last_xfer_cyc = cyc;
            end
            check("rsp_out_valid", {31'd0, rsp_out_valid}, {31'd0, prev_fwd});
            if (rsp_out_valid) begin
                if (exp_rsp.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL rsp_unexpected: got %0h expected no byte", rsp_out_data);
                end else begin
                    check("rsp_out_data", {24'd0, rsp_out_data}, {24'd0, exp_rsp.pop_front()});
                end
            end
            if (prev_done) check("after_done_busy_done", {30'd0, busy, done}, 32'd0);
            if (done) begin
                check("error_at_done", {31'd0, error}, {31'd0, exp_err});
                done_count++;
                done_cyc = cyc;
            end
            prev_stall = tx_valid & ~tx_ready;
            prev_data  = tx_data;
            prev_done  = done;
            prev_fwd   = rsp_valid & rsp_fwd;
        end
    end

    // Payload source and tx_ready pattern, updated just after each edge.
    always @(posedge clk) begin
        #1;
        if (pl_take && (pay_q.size() != 0)) void'(pay_q.pop_front());
        pl_valid = (pay_q.size() != 0);
        pl_data  = (pay_q.size() != 0) ? pay_q[0] : 8'h00;
        tx_ready = toggle_en ? ~tx_ready : ready_level;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // Command-level model: the byte stream a command must produce.
    task automatic issue(input logic [2:0] op, input logic [127:0] h,
                         input logic [15:0] nb, input logic [15:0] sl, input logic err);
        exp_err   = err;
        done_base = done_count;
        if ((op != 3'd0) && (op != 3'd7)) begin
            exp_tx.push_back(8'h00);
            exp_tx.push_back({5'd0, op});
            if (op == 3'd1) for (int i = 15; i >= 0; i--) exp_tx.push_back(h[i*8 +: 8]);
            if (op == 3'd2) begin
                exp_tx.push_back(nb[15:8]);
                exp_tx.push_back(nb[7:0]);
                for (int i = 0; i < pay_q.size(); i++) exp_tx.push_back(pay_q[i]);
            end
            if (op == 3'd5) begin
                exp_tx.push_back(sl[15:8]);
                exp_tx.push_back(sl[7:0]);
                mdl_str_len = sl;
            end
        end
        cmd_op = op; cmd_hash = h; cmd_num_bytes = nb; cmd_str_len = sl;
        cmd_start = 1'b1;
        tick();
        cmd_start = 1'b0;
        check("busy_after_start", {31'd0, busy}, 32'd1);
    endtask

    task automatic wait_drain(input int max);
        int i;
        for (i = 0; i < max && exp_tx.size() != 0; i++) tick();
        if (exp_tx.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL tx_drain_timeout: got %0d bytes left expected 0", exp_tx.size());
            exp_tx.delete();
        end
    endtask

    task automatic wait_done(input int max);
        int i;
        for (i = 0; i < max && done_count == done_base; i++) tick();
        check("done_seen", done_count, done_base + 1);
    endtask

    task automatic ack_pulse(input logic m);
        ack_in = 1'b1; match_in = m;
        tick();
        ack_in = 1'b0; match_in = 1'b0;
    endtask

    task automatic send_rsp(input int n, input int skip, input bit ack_last);
        for (int i = 0; i < n; i++) begin
            rsp_data  = rsp_src[i];
            rsp_valid = 1'b1;
            rsp_fwd   = (i >= skip);
            ack_in    = ack_last && (i == n - 1);
            tick();
        end
        rsp_valid = 1'b0; rsp_fwd = 1'b0; ack_in = 1'b0;
    endtask

    // RET/TEST: model decides the byte count, what lands in byte_pos and what is forwarded.
    task automatic run_rsp_cmd(input logic [2:0] op, input bit ack_last);
        int n;
        int skip;
        issue(op, 128'd0, 16'd0, 16'd0, 1'b0);
        n    = (op == 3'd3) ? 2 + int'(mdl_str_len / 16'd8) : 10;
        skip = (op == 3'd3) ? 2 : 0;
        last_n = n;
        if (op == 3'd3) mdl_byte_pos = {rsp_src[0], rsp_src[1]};
        for (int i = skip; i < n; i++) exp_rsp.push_back(rsp_src[i]);
        wait_drain(20);
        send_rsp(n, skip, ack_last);
        if (!ack_last) ack_pulse(1'b0);
        wait_done(10);
        check("byte_pos", {16'd0, byte_pos}, {16'd0, mdl_byte_pos});
        check("rsp_all_seen", exp_rsp.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        reset = 1'b1; cmd_start = 1'b0; cmd_op = 3'd0; cmd_hash = 128'd0;
        cmd_num_bytes = 16'd0; cmd_str_len = 16'd0; rsp_data = 8'h00; rsp_valid = 1'b0;
        rsp_fwd = 1'b0; ack_in = 1'b0; match_in = 1'b0; exp_err = 1'b0;
        mdl_str_len = 16'h0098; mdl_byte_pos = 16'h0000;
        tick(); tick();
        reset = 1'b0;
        tick();
        check("reset_outputs", {24'd0, busy, done, error, match, tx_valid, pl_ready, rsp_out_valid, 1'b0}, 32'd0);
        check("reset_byte_pos", {16'd0, byte_pos}, 32'd0);

        // SET
        issue(3'd1, 128'h00112233445566778899AABBCCDDEEFF, 16'd0, 16'd0, 1'b0);
        check("model_set_len", exp_tx.size(), 18);
        check("model_set_b3", {24'd0, exp_tx[3]}, 32'h11);
        check("model_set_last", {24'd0, exp_tx[17]}, 32'hFF);
        wait_drain(40);
        repeat (3) tick();
        ack_pulse(1'b0);
        wait_done(10);

        // PROC with tx_ready toggling
        pay_q = {8'h41, 8'h42, 8'h43};
        toggle_en = 1'b1;
        issue(3'd2, 128'd0, 16'd3, 16'd0, 1'b0);
        check("model_proc_len", exp_tx.size(), 7);
        wait_drain(60);
        toggle_en = 1'b0;
        tick();
        ack_pulse(1'b1);
        wait_done(10);
        check("match_latched", {31'd0, match}, 32'd1);

        // STR_LEN then RET
        issue(3'd5, 128'd0, 16'd0, 16'h0020, 1'b0);
        wait_drain(20);
        ack_pulse(1'b0);
        wait_done(10);
        rsp_src = {8'h00, 8'h05, 8'h61, 8'h62, 8'h63, 8'h64};
        run_rsp_cmd(3'd3, 1'b0);
        check("ret_len_0x20", last_n, 6);
        check("ret_byte_pos", {16'd0, byte_pos}, 32'h0005);

        // TEST countdown
        rsp_src = {8'h0A, 8'h09, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01};
        run_rsp_cmd(3'd4, 1'b0);

        // TEST with ack on the same cycle as the last byte
        run_rsp_cmd(3'd4, 1'b1);

        // Bad ops
        issue(3'd0, 128'd0, 16'd0, 16'd0, 1'b1);
        wait_done(5);
        issue(3'd7, 128'd0, 16'd0, 16'd0, 1'b1);
        wait_done(5);

        // RET with premature ack after one response byte
        issue(3'd3, 128'd0, 16'd0, 16'd0, 1'b1);
        wait_drain(20);
        rsp_src = {8'h00};
        mdl_byte_pos = {mdl_byte_pos[7:0], 8'h00};
        send_rsp(1, 2, 1'b0);
        ack_pulse(1'b0);
        wait_done(10);
        check("premature_byte_pos", {16'd0, byte_pos}, {16'd0, mdl_byte_pos});

        // CLOSE with no ack: watchdog abort after TMO idle cycles
        issue(3'd6, 128'd0, 16'd0, 16'd0, 1'b1);
        wait_drain(20);
        wait_done(40);
        check("timeout_distance", done_cyc - last_xfer_cyc, TMO + 1);

        // Reset while waiting for payload
        pay_q.delete();
        issue(3'd2, 128'd0, 16'd4, 16'd0, 1'b0);
        wait_drain(20);
        tick(); tick();
        check("payload_pl_ready", {30'd0, pl_ready, tx_valid}, 32'd2);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        mdl_str_len = 16'h0098;
        check("reset_mid_cmd", {30'd0, tx_valid, busy}, 32'd0);
        repeat (20) tick();
        check("no_done_after_reset", done_count, done_base);

        // Shadow length back at default: RET expects 2 + 19 bytes
        rsp_src = {8'h00, 8'h13};
        for (int i = 0; i < 19; i++) rsp_src.push_back(8'h30 + 8'(i));
        run_rsp_cmd(3'd3, 1'b0);
        check("ret_len_default", last_n, 21);
        check("ret_default_byte_pos", {16'd0, byte_pos}, 32'h0013);

        check("tx_queue_empty", exp_tx.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
